// File: rtl/rom_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_sequencer_if
// Description : Byte-stream link between the ROM sequencer and the display
//               byte transmitter (valid/ready with command/data flag).
//               master : drives o_valid/o_byte/o_dc, samples o_ready
//               slave  : samples o_valid/o_byte/o_dc, drives o_ready
// Revision    : 1.0  initial release
// ============================================================================
interface rom_sequencer_if;
  logic       o_valid;  // byte available
  logic       o_ready;  // downstream accepts byte
  logic [7:0] o_byte;   // byte payload
  logic       o_dc;     // 0 = command, 1 = data

  modport master (
    output o_valid,
    output o_byte,
    output o_dc,
    input  o_ready
  );

  modport slave (
    input  o_valid,
    input  o_byte,
    input  o_dc,
    output o_ready
  );
endinterface
`default_nettype wire

// File: rtl/rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rom_sequencer
// Description : Walks a ROM of display-init / drawing entries from address 0.
//               Each 10-bit entry is {opcode[1:0], arg[7:0]}:
//                 00 command byte, 01 data byte, 10 delay arg ms, 11 end.
//               Bytes go out on a valid/ready stream; delays count
//               arg*TICKS_PER_MS clocks; the end entry (or running past the
//               last address) parks the sequencer in DONE.
// Ports       : clk, rst      clock, synchronous active-high reset
//               start         begin a sequence (honoured in IDLE/DONE only)
//               rom_addr      registered ROM address
//               rom_data      ROM entry, valid one clock after rom_addr
//               bus           byte stream (master side)
//               busy, done    status
// Revision    : 1.0  initial release
// ============================================================================
module rom_sequencer #(
  parameter int L            = 32,
  parameter int CLK_HZ       = 12_000_000,
  parameter int TICKS_PER_MS = CLK_HZ / 1000
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 start,
  output logic [$clog2(L)-1:0]      rom_addr,
  input  wire logic [9:0]           rom_data,
  rom_sequencer_if.master           bus,
  output logic                      busy,
  output logic                      done
);

  localparam int c_AW        = $clog2(L);
  localparam int c_MAX_TICKS = 255 * TICKS_PER_MS;
  // Counter wide enough for the longest delay (arg = 255).
  localparam int c_CNT_W     = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS + 1) : 1;

  localparam logic [c_AW-1:0]    c_LAST  = c_AW'(L - 1);
  localparam logic [c_CNT_W-1:0] c_TICKS = c_CNT_W'(TICKS_PER_MS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_SEND   = 3'd3,
    S_DELAY  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_AW-1:0]      r_addr,  w_addr_nxt;
  logic [7:0]           r_byte,  w_byte_nxt;
  logic                 r_dc,    w_dc_nxt;
  logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;

  logic [1:0]           w_op;
  logic [7:0]           w_arg;
  logic [c_CNT_W-1:0]   w_delay_ticks;
  logic                 w_adv;

  assign w_op          = rom_data[9:8];
  assign w_arg         = rom_data[7:0];
  assign w_delay_ticks = c_CNT_W'(w_arg) * c_TICKS;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_byte  <= '0;
      r_dc    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_byte  <= w_byte_nxt;
      r_dc    <= w_dc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. w_adv requests the "advance" step, which is shared by
  // the handshake, delay expiry and zero-length delay paths and resolved
  // after the case statement.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_byte_nxt  = r_byte;
    w_dc_nxt    = r_dc;
    w_cnt_nxt   = r_cnt;
    w_adv       = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
        end
      end

      // ROM registers rom_addr at the end of this cycle.
      S_FETCH: w_state_nxt = S_DECODE;

      S_DECODE: begin
        case (w_op)
          2'b00, 2'b01: begin
            w_state_nxt = S_SEND;
            w_byte_nxt  = w_arg;
            w_dc_nxt    = w_op[0];
          end
          2'b10: begin
            if (w_arg != 8'd0) begin
              w_state_nxt = S_DELAY;
              w_cnt_nxt   = w_delay_ticks - 1'b1;
            end else begin
              w_adv = 1'b1;
            end
          end
          default: w_state_nxt = S_DONE;
        endcase
      end

      // o_valid is high for the whole SEND state, so ready alone completes it.
      S_SEND: begin
        if (bus.o_ready) begin
          w_adv = 1'b1;
        end
      end

      S_DELAY: begin
        if (r_cnt == '0) begin
          w_adv = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Running past the last entry behaves like an end entry: no wrap.
    if (w_adv) begin
      if (r_addr == c_LAST) begin
        w_state_nxt = S_DONE;
      end else begin
        w_addr_nxt  = r_addr + 1'b1;
        w_state_nxt = S_FETCH;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rom_addr    = r_addr;
  assign bus.o_valid = (r_state == S_SEND);
  assign bus.o_byte  = r_byte;
  assign bus.o_dc    = r_dc;
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_sequencer
// Description : Self-checking bench for rom_sequencer (L=4, TICKS_PER_MS=4).
//               Directed vector table, hand-written reset/restart sequences
//               and randomized ROM/ready patterns against a timeline model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rom_sequencer;
  localparam int L = 4;
  localparam int T = 4;
  localparam int RT = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] rom_addr;
  logic [9:0] rom_q;
  logic       busy;
  logic       done;

  rom_sequencer_if bus ();

  rom_sequencer #(
    .L            (L),
    .CLK_HZ       (12_000_000),
    .TICKS_PER_MS (T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_q),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Registered ROM, one clock of latency.
  logic [9:0] rom_mem [L];
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  // Edge counter: after posedge k settles, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ready seen at edge e is rdy_tab[e % RT].
  bit rdy_tab [RT];
  always @(posedge clk) begin
    #1;
    bus.o_ready = rdy_tab[(cyc + 1) % RT];
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------------------------------------------------------- monitor
  int         hs_edge [$];
  logic [8:0] hs_data [$];
  int         vrise   [$];
  int         done_edge = -1;
  int         busy_cnt  = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0, prev_done = 1'b0;
  logic [8:0] prev_d = '0;

  always @(negedge clk) begin
    if (!rst && prev_v && !prev_r) begin
      chk("hold_valid", bus.o_valid, 1);
      chk("hold_data", {bus.o_dc, bus.o_byte}, prev_d);
    end
    if (bus.o_valid && bus.o_ready) begin
      hs_edge.push_back(cyc + 1);
      hs_data.push_back({bus.o_dc, bus.o_byte});
    end
    if (bus.o_valid && !prev_v) vrise.push_back(cyc);
    if (done && !prev_done && done_edge < 0) done_edge = cyc;
    if (busy) busy_cnt++;
    prev_v    = bus.o_valid;
    prev_r    = bus.o_ready;
    prev_d    = {bus.o_dc, bus.o_byte};
    prev_done = done;
  end

  task automatic clear_mon();
    hs_edge.delete();
    hs_data.delete();
    vrise.delete();
    done_edge = -1;
    busy_cnt  = 0;
  endtask

  // --------------------------------------------------------------- expected
  int         exp_edge [$];   // handshake edges relative to start edge
  logic [8:0] exp_data [$];
  int         exp_vr, exp_done, exp_addr;

  typedef struct {
    logic [3:0][9:0] rom;
    int              bp;      // ready low for this many edges from N+3
    int              nb;
    logic [3:0][8:0] bytes;
    logic [3:0][7:0] hs;
    int              vr;
    int              dn;
    int              addr;
  } vec_t;

  vec_t vecs [6];

  task automatic load_exp(input int i);
    exp_edge.delete();
    exp_data.delete();
    for (int j = 0; j < vecs[i].nb; j++) begin
      exp_edge.push_back(int'(vecs[i].hs[j]));
      exp_data.push_back(vecs[i].bytes[j]);
    end
    exp_vr   = vecs[i].vr;
    exp_done = vecs[i].dn;
    exp_addr = vecs[i].addr;
  endtask

  // Timeline model: each entry costs two clocks to fetch/decode; a byte then
  // waits for the first ready edge; a delay adds arg*T clocks.
  task automatic model(input int n);
    int t, d, h, a;
    logic [9:0] e;
    t = 0; a = 0;
    exp_edge.delete();
    exp_data.delete();
    exp_vr = -1; exp_done = -1;
    for (int s = 0; s < L && exp_done < 0; s++) begin
      e = rom_mem[a];
      d = t + 2;
      if (e[9] == 1'b0) begin
        if (exp_vr < 0) exp_vr = d;
        h = d + 1;
        while (!rdy_tab[(n + h) % RT] && h < d + 4000) h++;
        exp_edge.push_back(h);
        exp_data.push_back(e[8:0]);
        t = h;
      end else if (e[8] == 1'b0) begin
        t = d + int'(e[7:0]) * T;
      end else begin
        exp_done = d;
      end
      if (exp_done < 0) begin
        if (a == L - 1) exp_done = t;
        else a++;
      end
    end
    exp_addr = a;
  endtask

  // ------------------------------------------------------------------ tasks
  task automatic fill_rdy(input bit v);
    for (int k = 0; k < RT; k++) rdy_tab[k] = v;
  endtask

  task automatic load_rom(input logic [3:0][9:0] r);
    for (int a = 0; a < L; a++) rom_mem[a] = r[a];
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic pulse_start(output int n);
    @(posedge clk); #2 start = 1'b1;
    n = cyc + 1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_edge < 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", int'(done_edge >= 0), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_all(input string tag, input int n);
    chk({tag, "_nbytes"}, hs_data.size(), exp_data.size());
    for (int j = 0; j < hs_data.size() && j < exp_data.size(); j++) begin
      chk({tag, "_byte"}, hs_data[j], exp_data[j]);
      chk({tag, "_hs_edge"}, hs_edge[j] - n, exp_edge[j]);
    end
    chk({tag, "_first_valid"}, (vrise.size() > 0) ? vrise[0] - n : -1, exp_vr);
    chk({tag, "_done_edge"}, done_edge - n, exp_done);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_done);
    chk({tag, "_final_addr"}, rom_addr, exp_addr);
    chk({tag, "_done_level"}, done, 1);
    chk({tag, "_busy_level"}, busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, bus.o_valid, 0);
    chk({tag, "_byte"}, bus.o_byte, 0);
    chk({tag, "_dc"}, bus.o_dc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, rom_addr, 0);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ------------------------------------------------------------------- main
  initial begin
    int n;
    logic [3:0][9:0] r;

    // rom (index 0 rightmost), bp, nb, bytes, handshake edges, valid, done, addr
    vecs[0] = '{{10'h000, 10'h300, 10'h148, 10'h036}, 0, 2,
                {9'h0, 9'h0, 9'h148, 9'h036}, {8'd0, 8'd0, 8'd6, 8'd3}, 2, 8, 2};
    vecs[1] = '{{10'h000, 10'h300, 10'h148, 10'h036}, 10, 2,
                {9'h0, 9'h0, 9'h148, 9'h036}, {8'd0, 8'd0, 8'd16, 8'd13}, 2, 18, 2};
    vecs[2] = '{{10'h000, 10'h300, 10'h0AA, 10'h203}, 0, 1,
                {9'h0, 9'h0, 9'h0, 9'h0AA}, {8'd0, 8'd0, 8'd0, 8'd17}, 16, 19, 2};
    vecs[3] = '{{10'h000, 10'h300, 10'h0AA, 10'h200}, 0, 1,
                {9'h0, 9'h0, 9'h0, 9'h0AA}, {8'd0, 8'd0, 8'd0, 8'd5}, 4, 7, 2};
    vecs[4] = '{{10'h004, 10'h003, 10'h002, 10'h001}, 0, 4,
                {9'h004, 9'h003, 9'h002, 9'h001}, {8'd12, 8'd9, 8'd6, 8'd3}, 2, 12, 3};
    vecs[5] = '{{10'h000, 10'h000, 10'h000, 10'h300}, 0, 0,
                {9'h0, 9'h0, 9'h0, 9'h0}, {8'd0, 8'd0, 8'd0, 8'd0}, -1, 2, 0};

    rst = 1'b1; start = 1'b0;
    fill_rdy(1'b1);
    for (int a = 0; a < L; a++) rom_mem[a] = '0;
    do_reset();
    @(negedge clk);
    chk_reset_vals("reset");

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      load_rom(vecs[i].rom);
      fill_rdy(1'b1);
      do_reset();
      clear_mon();
      pulse_start(n);
      for (int e = n + 3; e < n + 3 + vecs[i].bp; e++) rdy_tab[e % RT] = 1'b0;
      wait_done(400);
      load_exp(i);
      compare_all($sformatf("vec%0d", i), n);
    end

    // Reset while a byte is being offered, then replay from entry 0
    load_rom(vecs[0].rom);
    fill_rdy(1'b0);
    do_reset();
    clear_mon();
    pulse_start(n);
    repeat (3) @(negedge clk);
    chk("midsend_valid", bus.o_valid, 1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("midsend_rst");
    @(posedge clk); #2 rst = 1'b0;
    fill_rdy(1'b1);
    clear_mon();
    pulse_start(n);
    wait_done(400);
    load_exp(0);
    compare_all("replay", n);

    // start while busy is ignored
    load_rom(vecs[2].rom);
    do_reset();
    clear_mon();
    pulse_start(n);
    repeat (2) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(400);
    load_exp(2);
    compare_all("start_busy", n);

    // start in DONE replays the sequence
    clear_mon();
    pulse_start(n);
    @(negedge clk);
    chk("restart_done_clear", done, 0);
    wait_done(400);
    load_exp(2);
    compare_all("restart", n);

    // Randomized ROM contents and ready patterns
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < L; a++) begin
        int k;
        k = $urandom_range(0, 9);
        if (k <= 5)      r[a] = {1'b0, k[0], 8'($urandom_range(0, 255))};
        else if (k <= 8) r[a] = {2'b10, 8'($urandom_range(0, 6))};
        else             r[a] = 10'h300;
      end
      load_rom(r);
      for (int k = 0; k < RT; k++) rdy_tab[k] = ($urandom_range(0, 9) < 6);
      do_reset();
      clear_mon();
      pulse_start(n);
      model(n);
      wait_done(3000);
      compare_all($sformatf("rand%0d", it), n);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
`default_nettype wire
